wb_stream_writer: RTL and testbench

- Wishbone master that turns a 16-bit sample stream (mic/ADC datapath) into sequential writes into the adjacent wishbone BlockRAM. The BlockRAM is used as a ping-pong ring buffer.
- Sits directly upstream of the BlockRAM on its port (stb/cyc/we/adr/dat/sel; no ack).
- Signals the host with half-full and full pulses, so one half can be read while the other fills.

---
 rtl/wb_stream_writer.sv | 178 +++++++++++++++++
 tb/tb_wb_stream_writer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_writer.sv
// wb_stream_writer: Wishbone master that streams 16-bit samples into a
// ping-pong ring buffer in an adjacent BlockRAM (write-only port, no ack).
//
// Ports:
//   clk_i, resetn         clock, asynchronous active-low reset
//   enable_i              capture enable; low = idle, ring index cleared
//   s_data_i/s_valid_i    sample stream in; s_ready_o is combinational
//   wb_*_o                Wishbone write port (stb/cyc/we/adr/dat/sel)
//   irq_half_o/irq_full_o one-cycle pulses with the last write of each half
//   wr_index_o            ring index of the next write
//   overrun_o             sticky overrun flag (0 unless overrun logic built)
//
// Build option: define WB_STREAM_WRITER_OVERRUN_EN to add buf_release_i and
// per-half pending tracking; a sample that would enter a still-pending half is
// dropped and overrun_o is set. Without it the ring overwrites freely.
module wb_stream_writer #(
  parameter int unsigned adr_width = 10,
  parameter logic [13:0] base_adr  = 14'h0000
) (
  input  logic                 clk_i,
  input  logic                 resetn,
  input  logic                 enable_i,
  input  logic [15:0]          s_data_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o,
  output logic                 wb_we_o,
  output logic [13:0]          wb_adr_o,
  output logic [15:0]          wb_dat_o,
  output logic [1:0]           wb_sel_o,
  output logic                 irq_half_o,
  output logic                 irq_full_o,
  output logic [adr_width-1:0] wr_index_o,
`ifdef WB_STREAM_WRITER_OVERRUN_EN
  input  logic                 buf_release_i,
`endif
  output logic                 overrun_o
);

  localparam logic [adr_width-1:0] IDX_ONE       = {{(adr_width-1){1'b0}}, 1'b1};
  localparam logic [adr_width-1:0] IDX_LAST      = {adr_width{1'b1}};
  localparam logic [adr_width-1:0] IDX_HALF_LAST = {1'b0, {(adr_width-1){1'b1}}};

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [adr_width-1:0] idx_q, idx_d;
  logic                 stb_q, stb_d;
  logic [13:0]          adr_q, adr_d;
  logic [15:0]          dat_q, dat_d;
  logic                 half_q, half_d;
  logic                 full_q, full_d;
  logic                 ready_c;
  logic                 accept_c;
  logic                 blocked_c;
  logic                 wr_c;

  // State register and registered Wishbone/IRQ outputs
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      stb_q   <= 1'b0;
      adr_q   <= base_adr;
      dat_q   <= '0;
      half_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      half_q  <= half_d;
      full_q  <= full_d;
    end
  end

  // Next-state logic: one write issued the cycle after each accepted sample
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stb_d    = 1'b0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    half_d   = 1'b0;
    full_d   = 1'b0;
    ready_c  = (state_q == ST_RUN) && enable_i;
    accept_c = ready_c && s_valid_i;
    wr_c     = accept_c && !blocked_c;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (wr_c) begin
          stb_d  = 1'b1;
          // base_adr is depth-aligned, so the index never carries into it
          adr_d  = base_adr + 14'(idx_q);
          dat_d  = s_data_i;
          half_d = (idx_q == IDX_HALF_LAST);
          full_d = (idx_q == IDX_LAST);
          idx_d  = idx_q + IDX_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef WB_STREAM_WRITER_OVERRUN_EN
  localparam logic [adr_width-1:0] IDX_HALF = {1'b1, {(adr_width-1){1'b0}}};

  logic [1:0] pend_q, pend_d;
  logic       last_q, last_d;
  logic       ovr_q, ovr_d;

  // Pending halves, the half set most recently, and the sticky overrun flag
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      pend_q <= '0;
      last_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
      ovr_q  <= ovr_d;
    end
  end

  // A write is blocked while its target half start is still pending
  assign blocked_c = ((idx_q == '0) && pend_q[0]) || ((idx_q == IDX_HALF) && pend_q[1]);

  // Release frees the oldest pending half before this cycle's IRQ sets one
  always_comb begin
    pend_d = pend_q;
    last_d = last_q;
    ovr_d  = ovr_q || (accept_c && blocked_c);
    if (buf_release_i) begin
      if (pend_q == 2'b11) pend_d[~last_q] = 1'b0;
      else                 pend_d = '0;
    end
    if (half_q) begin
      pend_d[0] = 1'b1;
      last_d    = 1'b0;
    end
    if (full_q) begin
      pend_d[1] = 1'b1;
      last_d    = 1'b1;
    end
    if (!enable_i) begin
      pend_d = '0;
      ovr_d  = 1'b0;
    end
  end

  assign overrun_o = ovr_q;
`else
  assign blocked_c = 1'b0;
  assign overrun_o = 1'b0;
`endif

  assign s_ready_o  = ready_c;
  assign wb_stb_o   = stb_q;
  assign wb_cyc_o   = stb_q;
  assign wb_we_o    = stb_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = 2'b11;
  assign irq_half_o = half_q;
  assign irq_full_o = full_q;
  assign wr_index_o = idx_q;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Testbench for wb_stream_writer (adr_width = 4, base 0x100). A transaction-
// level model tracks the ring index, last bus values and pending halves; each
// scenario task compares the DUT against it every cycle.
module tb_wb_stream_writer;

  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [13:0] BASE  = 14'h100;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable_i = 1'b0;
  logic [15:0]   s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic          wb_stb_o, wb_cyc_o, wb_we_o;
  logic [13:0]   wb_adr_o;
  logic [15:0]   wb_dat_o;
  logic [1:0]    wb_sel_o;
  logic          irq_half_o, irq_full_o;
  logic [AW-1:0] wr_index_o;
  logic          overrun_o;
`ifdef WB_STREAM_WRITER_OVERRUN_EN
  logic          buf_release_i = 1'b0;
`endif

  wb_stream_writer #(.adr_width(AW), .base_adr(BASE)) dut (
    .clk_i(clk), .resetn(resetn), .enable_i(enable_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .irq_half_o(irq_half_o), .irq_full_o(irq_full_o), .wr_index_o(wr_index_o),
`ifdef WB_STREAM_WRITER_OVERRUN_EN
    .buf_release_i(buf_release_i),
`endif
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_run;
  int          mi;
  logic [13:0] m_adr;
  logic [15:0] m_dat;
  bit          e_stb, e_half, e_full, m_ovr;
  int          pend[$];
  bit          exp_ready, obs_ready;
  logic [41:0] exp_vec;
  logic [41:0] obs_vec;

  assign obs_vec = {wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
                    irq_half_o, irq_full_o, wr_index_o, overrun_o};

  function automatic logic [41:0] pack_exp();
    return {e_stb, e_stb, e_stb, 2'b11, m_adr, m_dat, e_half, e_full, AW'(mi), m_ovr};
  endfunction

  function automatic bit pend_has(int h);
    foreach (pend[k]) if (pend[k] == h) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_run = 0; mi = 0; m_adr = BASE; m_dat = '0;
    e_stb = 0; e_half = 0; e_full = 0; m_ovr = 0;
    pend.delete();
    exp_vec = pack_exp();
  endtask

  // One clock of stimulus; the model advances by the ring-buffer rules
  task automatic drive(input bit en, input bit v, input logic [15:0] d, input bit rel);
    bit acc, blocked, wr;
    @(negedge clk);
    enable_i = en; s_valid_i = v; s_data_i = d;
`ifdef WB_STREAM_WRITER_OVERRUN_EN
    buf_release_i = rel;
`endif
    #1;
    obs_ready = s_ready_o;
    exp_ready = m_run && en;
    acc = exp_ready && v;
    blocked = 1'b0;
`ifdef WB_STREAM_WRITER_OVERRUN_EN
    blocked = acc && ((mi == 0 && pend_has(0)) || (mi == DEPTH/2 && pend_has(1)));
`endif
    if (rel && pend.size() > 0) void'(pend.pop_front());
    if (e_half) pend.push_back(0);
    if (e_full) pend.push_back(1);
    if (!en) pend.delete();
    m_ovr = en && (m_ovr || blocked);
    wr = acc && !blocked;
    e_stb = wr;
    e_half = wr && (mi == DEPTH/2 - 1);
    e_full = wr && (mi == DEPTH - 1);
    if (wr) begin
      m_adr = BASE + 14'(mi);
      m_dat = d;
      mi = (mi + 1) % DEPTH;
    end
    if (!(m_run && en)) mi = 0;
    m_run = en;
    exp_vec = pack_exp();
    @(posedge clk);
    #1;
`ifdef WB_STREAM_WRITER_OVERRUN_EN
    buf_release_i = 1'b0;
`endif
  endtask

  task automatic test_reset();
    model_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++; $display("FAIL reset_state: got %h exp %h", obs_vec, exp_vec);
    end
    @(negedge clk); resetn = 1'b1;
    drive(1, 0, 16'h0, 0);
    drive(1, 1, 16'h1234, 0);
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++; $display("FAIL reset_prewrite: got %h exp %h", obs_vec, exp_vec);
    end
    // Pull reset in the middle of the strobe cycle
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++; $display("FAIL reset_midwrite: got %h exp %h", obs_vec, exp_vec);
    end
    enable_i = 1'b0; s_valid_i = 1'b0;
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_stream();
    int half_adr = -1;
    int full_adr = -1;
    drive(1, 0, 16'h0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 16'hA000 + 16'(i), 0);
      checks += 2;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL stream_ready[%0d]: got %b exp %b", i, obs_ready, exp_ready);
      end
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL stream[%0d]: got %h exp %h", i, obs_vec, exp_vec);
      end
      if (irq_half_o === 1'b1) half_adr = int'(wb_adr_o);
      if (irq_full_o === 1'b1) full_adr = int'(wb_adr_o);
    end
    checks += 2;
    if (half_adr != 'h107) begin
      errors++; $display("FAIL irq_half_adr: got %h exp 107", half_adr);
    end
    if (full_adr != 'h10F) begin
      errors++; $display("FAIL irq_full_adr: got %h exp 10f", full_adr);
    end
  endtask

  task automatic test_wrap();
    drive(1, 1, 16'hBEEF, 0);
    checks += 2;
    if (obs_vec !== exp_vec) begin
      errors++; $display("FAIL wrap: got %h exp %h", obs_vec, exp_vec);
    end
    if (wb_adr_o !== BASE || wr_index_o !== AW'(1)) begin
      errors++; $display("FAIL wrap_adr: got adr %h idx %0d exp adr %h idx 1", wb_adr_o, wr_index_o, BASE);
    end
  endtask

  task automatic test_gapped();
    logic [AW-1:0] start_idx = wr_index_o;
    bit pat[3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1, pat[i], 16'h5500 + 16'(i), 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL gapped[%0d]: got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (wr_index_o !== AW'(start_idx + 2)) begin
      errors++; $display("FAIL gapped_advance: got %0d exp %0d", wr_index_o, AW'(start_idx + 2));
    end
  endtask

  task automatic test_disable();
    drive(0, 0, 16'h0, 0);
    drive(1, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 16'hC000 + 16'(i), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 16'hDEAD, 0);
      checks += 2;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL disable_ready[%0d]: got %b exp %b", i, obs_ready, exp_ready);
      end
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL disable[%0d]: got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    drive(1, 1, 16'hF00D, 0);
    drive(1, 1, 16'hC0DE, 0);
    checks += 2;
    if (obs_vec !== exp_vec) begin
      errors++; $display("FAIL reenable: got %h exp %h", obs_vec, exp_vec);
    end
    if (wb_stb_o !== 1'b1 || wb_adr_o !== BASE) begin
      errors++; $display("FAIL reenable_adr: got stb %b adr %h exp stb 1 adr %h", wb_stb_o, wb_adr_o, BASE);
    end
  endtask

`ifdef WB_STREAM_WRITER_OVERRUN_EN
  task automatic test_overrun();
    drive(0, 0, 16'h0, 0);
    drive(1, 0, 16'h0, 0);
    for (int i = 0; i < DEPTH; i++) drive(1, 1, 16'h7000 + 16'(i), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 16'hE000 + 16'(i), 0);
      checks += 2;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL overrun_drop[%0d]: got %h exp %h", i, obs_vec, exp_vec);
      end
      if (overrun_o !== 1'b1 || wb_stb_o !== 1'b0) begin
        errors++; $display("FAIL overrun_flag[%0d]: got ovr %b stb %b exp ovr 1 stb 0", i, overrun_o, wb_stb_o);
      end
    end
    drive(1, 0, 16'h0, 1);
    drive(1, 1, 16'h1111, 0);
    checks += 2;
    if (obs_vec !== exp_vec) begin
      errors++; $display("FAIL overrun_release: got %h exp %h", obs_vec, exp_vec);
    end
    if (wb_stb_o !== 1'b1 || wb_adr_o !== BASE) begin
      errors++; $display("FAIL overrun_resume: got stb %b adr %h exp stb 1 adr %h", wb_stb_o, wb_adr_o, BASE);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit en  = ($urandom_range(0, 19) != 0);
      bit v   = ($urandom_range(0, 3) != 0);
      bit rel = ($urandom_range(0, 7) == 0);
`ifndef WB_STREAM_WRITER_OVERRUN_EN
      rel = 1'b0;
`endif
      drive(en, v, 16'($urandom), rel);
      checks += 2;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL random_ready[%0d]: got %b exp %b", i, obs_ready, exp_ready);
      end
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL random[%0d]: got %h exp %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_gapped();
    test_disable();
`ifdef WB_STREAM_WRITER_OVERRUN_EN
    test_overrun();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
